regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Write-back stage between the per-core execute units of the multi-core `cpu` and the shared register file. Each core presents at most one register write per cycle; the arbiter buffers them in per-core FIFOs and drains them one per cycle into the single regfile write port using round-robin priority. When a core's FIFO is full, that core is stalled. This block lets N cores share one regfile without dropping writes.

## Interface
- `CORES`, 4, number of cores feeding the arbiter (1–8).
- `DEPTH`, 2, entries per core FIFO (power of two, ≥2).
- `ADDR_W`, 5, register address width.
- `DATA_W`, 32, register data width.

- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `core_we`  in  CORES  per-core write request.
- `core_waddr`  in  CORES*ADDR_W  per-core destination register; core i occupies bits [i*ADDR_W +: ADDR_W].
- `core_wdata`  in  CORES*DATA_W  per-core write data, packed the same way.
- `core_stall`  out  CORES  core i must hold its request; a request is ignored while its stall is high.
- `rf_we`  out  1  regfile write enable.
- `rf_waddr`  out  ADDR_W  regfile write address.
- `rf_wdata`  out  DATA_W  regfile write data.
- `rf_wcore`  out  $clog2(CORES)  source core of the current write (debug and trace).
- `idle`  out  1  high when all FIFOs are empty and `rf_we` is low.

## Operation
- Enqueue: at a rising edge where `core_we[i]` is high and `core_stall[i]` is low, push {waddr, wdata} into FIFO i.
- Writes to register 0 are discarded at enqueue. They are never queued, never appear on `rf_*`, and do not cause a stall.
- Stall: `core_stall[i]` = FIFO i full, computed from registered occupancy before this cycle's dequeue. There is no full-FIFO bypass.
- Arbitration: each cycle, among cores with non-empty FIFOs, grant the first at or after pointer `rr`, searching upward modulo CORES.
- After a grant to core g, `rr` becomes g+1 mod CORES. `rr` is unchanged when nothing is granted.
- Dequeue: the granted FIFO pops at the edge, and the head entry is registered onto `rf_we=1`, `rf_waddr`, `rf_wdata`, `rf_wcore=g`.
- With no grant, `rf_we`=0 and `rf_waddr`/`rf_wdata`/`rf_wcore` hold their last values.
- Ordering:
  - Writes from one core reach the regfile in issue order.
  - Writes from different cores are ordered by arbitration only. Same-address writes from different cores in the same cycle land in round-robin order; the last one granted wins.
- Simultaneous push and pop on one FIFO in the same cycle: occupancy is unchanged, and both operations take effect.
- Wrap-around: FIFO pointers are $clog2(DEPTH)+1 bits. Full means the MSBs differ and the rest are equal; empty means the pointers are equal.

## Timing
- Reset (asserted asynchronously, released synchronously to `clk`): all FIFOs are emptied, `rr`=0, and outputs are `rf_we`=0, `rf_waddr`=0, `rf_wdata`=0, `rf_wcore`=0, `core_stall`=0, `idle`=1.
- Reset mid-operation: queued writes are lost; nothing partial reaches `rf_*`.
- Latency:
  - A request accepted at edge k, found at the FIFO head and granted, drives `rf_*` after edge k+1.
  - The regfile commits it at edge k+2.
  - Minimum latency is 2 cycles; worst case is 2 + (CORES·DEPTH − 1) cycles.
- Throughput: 1 write per cycle total. A single core issuing every cycle with no contention never stalls.
- `core_stall` is a registered-state function and is stable for the whole cycle.

## Structure
- Package `cpu_wb_pkg`:
  - `ADDR_W`/`DATA_W` defaults.
  - Typedef `wb_req_t` {addr, data}.
  - Function `rr_pick(req_mask, rr)` returning the grant index.
- Sub-module `wb_fifo`: a single-core synchronous FIFO of `wb_req_t` with push, pop, full, empty and head outputs. It is instantiated CORES times via generate.
- The arbiter pointer and output registers live in the top module.

## Test plan
- Reset: drive `reset_n`=0 with requests pending → `rf_we`=0, `idle`=1, `core_stall`=0000. After release, the first write appears no earlier than 2 edges after its request.
- Single write: core 0 writes r9=1 once → exactly one `rf_we` pulse with r9/1, `rf_wcore`=0, 2 cycles after the request.
- Four-core burst: in one cycle, cores 0..3 write r9=1, r10=2, r11=2, r12=6 → four consecutive `rf_we` cycles in order 9, 10, 11, 12, after which `idle`=1.
- Back-pressure: core 2 issues 4 writes on back-to-back cycles (r1..r4 = 0xA..0xD) while cores 0, 1, 3 each keep their FIFOs busy →
  - `core_stall[2]` asserts when FIFO 2 holds 2 entries.
  - The held request is accepted after the stall drops.
  - The regfile receives r1..r4 in order with no loss or duplication.
- r0 discard: core 1 writes r0=0xFFFF_FFFF and then r5=7 → only r5/7 appears on `rf_*`, and `core_stall[1]` never asserts.
- Mid-operation reset: pulse `reset_n` low for half a cycle while three FIFOs hold data → `rf_we` falls immediately, and no queued write appears after release.

Source files
------------

// File: rtl/cpu_wb_pkg.sv
// Shared types and helpers for the write-back arbiter: request record and round-robin pick.
// Latency: n/a (types and a combinational function only).
// Backpressure: n/a.
package cpu_wb_pkg;

    localparam int WB_ADDR_W = 5;
    localparam int WB_DATA_W = 32;

    // Upper bound on cores; the pick function works on a fixed 8-bit mask.
    localparam int MAX_CORES = 8;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_req_t;

    // Returns the first set bit at or above rr, wrapping. Mask bits at or above
    // the real core count are always zero, so wrapping modulo 8 visits the live
    // cores in the same order as wrapping modulo CORES.
    function automatic logic [2:0] rr_pick(input logic [MAX_CORES-1:0] req_mask,
                                           input logic [2:0]           rr);
        logic [2:0] idx;
        rr_pick = rr;
        for (int k = MAX_CORES - 1; k >= 0; k--) begin
            idx = rr + 3'(k);
            if (req_mask[idx]) begin
                rr_pick = idx;
            end
        end
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Bundle between the per-core execute units, the arbiter and the regfile write port.
// Latency: n/a (wires only).
// Backpressure: core_stall travels back to the cores on this bundle.
interface regfile_write_arbiter_if #(
    parameter int CORES  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    localparam int CW = (CORES > 1) ? $clog2(CORES) : 1;

    logic [CORES-1:0]        core_we;
    logic [CORES*ADDR_W-1:0] core_waddr;
    logic [CORES*DATA_W-1:0] core_wdata;
    logic [CORES-1:0]        core_stall;
    logic                    rf_we;
    logic [ADDR_W-1:0]       rf_waddr;
    logic [DATA_W-1:0]       rf_wdata;
    logic [CW-1:0]           rf_wcore;
    logic                    idle;

    // Cores and regfile side.
    modport master (
        output core_we, core_waddr, core_wdata,
        input  core_stall, rf_we, rf_waddr, rf_wdata, rf_wcore, idle
    );

    // Arbiter side.
    modport slave (
        input  core_we, core_waddr, core_wdata,
        output core_stall, rf_we, rf_waddr, rf_wdata, rf_wcore, idle
    );
endinterface

// File: rtl/wb_fifo.sv
// Per-core FIFO of pending register writes.
// Latency: entry visible at head the cycle after push.
// Backpressure: full is registered state; a push while full is ignored.
module wb_fifo
    import cpu_wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    reset_n,
    input  logic    push,
    input  logic    pop,
    input  wb_req_t din,
    output logic    full,
    output logic    empty,
    output wb_req_t head
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    wb_req_t       mem [DEPTH];

    logic do_push;
    logic do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rptr[AW-1:0]];

    // Pointer update; the extra MSB distinguishes full from empty on wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + PW'(1);
            if (do_pop)  rptr <= rptr + PW'(1);
        end
    end

    // Storage needs no reset: empty pointers make stale contents invisible.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Buffers per-core register writes and drains one per cycle to the regfile, round-robin.
// Latency: 2 cycles request-to-commit when uncontended, registered rf_* outputs.
// Backpressure: core_stall[i] = FIFO i full from registered occupancy; held request retried.
module regfile_write_arbiter #(
    parameter int CORES  = 4,
    parameter int DEPTH  = 2,
    parameter int ADDR_W = cpu_wb_pkg::WB_ADDR_W,
    parameter int DATA_W = cpu_wb_pkg::WB_DATA_W
) (
    input  logic                    clk,
    input  logic                    reset_n,
    regfile_write_arbiter_if.slave  bus
);
    import cpu_wb_pkg::*;

    localparam int CW = (CORES > 1) ? $clog2(CORES) : 1;

    logic [CORES-1:0]     full;
    logic [CORES-1:0]     empty;
    logic [CORES-1:0]     push;
    logic [CORES-1:0]     pop;
    wb_req_t              heads [CORES];

    logic [MAX_CORES-1:0] req_mask;
    logic [2:0]           rr;
    logic [2:0]           grant;
    logic                 gnt_vld;
    wb_req_t              sel;

    logic                 rf_we_q;
    logic [ADDR_W-1:0]    rf_waddr_q;
    logic [DATA_W-1:0]    rf_wdata_q;
    logic [CW-1:0]        rf_wcore_q;

    // One FIFO per core; writes to r0 never enter the queue.
    for (genvar g = 0; g < CORES; g++) begin : g_core
        wb_req_t din;
        assign din.addr = bus.core_waddr[g*ADDR_W +: ADDR_W];
        assign din.data = bus.core_wdata[g*DATA_W +: DATA_W];
        assign push[g]  = bus.core_we[g] && !full[g] && (din.addr != '0);

        wb_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk     (clk),
            .reset_n (reset_n),
            .push    (push[g]),
            .pop     (pop[g]),
            .din     (din),
            .full    (full[g]),
            .empty   (empty[g]),
            .head    (heads[g])
        );
    end

    // Requesting cores, widened to the fixed mask the pick function expects.
    always_comb begin
        req_mask = '0;
        for (int i = 0; i < CORES; i++) begin
            req_mask[i] = !empty[i];
        end
    end

    assign grant   = rr_pick(req_mask, rr);
    assign gnt_vld = |req_mask;

    // Pop the granted FIFO and route its head to the output register.
    always_comb begin
        pop = '0;
        sel = '0;
        for (int i = 0; i < CORES; i++) begin
            if (gnt_vld && (grant == 3'(i))) begin
                pop[i] = 1'b1;
                sel    = heads[i];
            end
        end
    end

    // Round-robin pointer and registered regfile write port; data holds when idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr         <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            rf_wcore_q <= '0;
        end else begin
            rf_we_q <= gnt_vld;
            if (gnt_vld) begin
                rr         <= (grant == 3'(CORES - 1)) ? 3'd0 : grant + 3'd1;
                rf_waddr_q <= sel.addr;
                rf_wdata_q <= sel.data;
                rf_wcore_q <= grant[CW-1:0];
            end
        end
    end

    assign bus.core_stall = full;
    assign bus.rf_we      = rf_we_q;
    assign bus.rf_waddr   = rf_waddr_q;
    assign bus.rf_wdata   = rf_wdata_q;
    assign bus.rf_wcore   = rf_wcore_q;
    assign bus.idle       = !gnt_vld && !rf_we_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: reset, latency, burst order, stall, r0 drop, mid reset.
// Latency: n/a.
// Backpressure: core 2 stimulus holds its request while core_stall[2] is high.
module tb_regfile_write_arbiter;

    localparam int CORES = 4;
    localparam int DEPTH = 2;
    localparam int AW    = 5;
    localparam int DW    = 32;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    regfile_write_arbiter_if #(.CORES(CORES), .ADDR_W(AW), .DATA_W(DW)) bus ();

    regfile_write_arbiter #(
        .CORES (CORES),
        .DEPTH (DEPTH),
        .ADDR_W(AW),
        .DATA_W(DW)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic req(input int c, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.core_we[c]               = we;
        bus.core_waddr[c*AW +: AW]   = a;
        bus.core_wdata[c*DW +: DW]   = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.core_we = '0;
        reset_n     = 1'b0;
        tick();
        tick();
        reset_n     = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] bdat [4];
        logic [4:0]  ga [4];
        logic [31:0] gd [4];
        int          idx2;
        int          cnt2;
        logic        acc2;
        int          cnt_we;

        bdat = '{32'd1, 32'd2, 32'd2, 32'd6};
        ga   = '{default: '0};
        gd   = '{default: '0};

        bus.core_we    = '0;
        bus.core_waddr = '0;
        bus.core_wdata = '0;

        // Reset with a request pending.
        req(0, 1'b1, 5'd3, 32'h33);
        repeat (3) tick();
        check("rst_we",    bus.rf_we,      0);
        check("rst_idle",  bus.idle,       1);
        check("rst_stall", bus.core_stall, 0);
        check("rst_addr",  bus.rf_waddr,   0);
        check("rst_data",  bus.rf_wdata,   0);
        check("rst_core",  bus.rf_wcore,   0);
        reset_n = 1'b1;
        tick();
        check("rst_lat_e1", bus.rf_we, 0);
        req(0, 1'b0, 5'd0, 32'h0);
        tick();
        check("rst_lat_we",   bus.rf_we,    1);
        check("rst_lat_addr", bus.rf_waddr, 3);
        check("rst_lat_data", bus.rf_wdata, 32'h33);
        tick();
        check("rst_lat_off",  bus.rf_we,    0);
        check("rst_lat_idle", bus.idle,     1);

        // Single write from core 0.
        req(0, 1'b1, 5'd9, 32'd1);
        tick();
        check("single_e1_we", bus.rf_we, 0);
        req(0, 1'b0, 5'd0, 32'd0);
        tick();
        check("single_we",   bus.rf_we,    1);
        check("single_addr", bus.rf_waddr, 9);
        check("single_data", bus.rf_wdata, 1);
        check("single_core", bus.rf_wcore, 0);
        tick();
        check("single_off",  bus.rf_we,    0);
        check("single_hold", bus.rf_waddr, 9);
        check("single_idle", bus.idle,     1);
        tick();
        check("single_once", bus.rf_we,    0);

        // Four-core burst in one cycle, starting from rr=0.
        do_reset();
        for (int c = 0; c < 4; c++) req(c, 1'b1, 5'(9 + c), bdat[c]);
        tick();
        bus.core_we = '0;
        check("burst_e1_we", bus.rf_we, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("burst%0d_we", k),   bus.rf_we,    1);
            check($sformatf("burst%0d_addr", k), bus.rf_waddr, 64'(9 + k));
            check($sformatf("burst%0d_data", k), bus.rf_wdata, bdat[k]);
            check($sformatf("burst%0d_core", k), bus.rf_wcore, 64'(k));
        end
        tick();
        check("burst_off",  bus.rf_we, 0);
        check("burst_idle", bus.idle,  1);

        // Writes to r0 are dropped at enqueue.
        req(1, 1'b1, 5'd0, 32'hFFFF_FFFF);
        tick();
        check("r0_stall_a", bus.core_stall[1], 0);
        check("r0_we_a",    bus.rf_we,         0);
        req(1, 1'b1, 5'd5, 32'd7);
        tick();
        check("r0_we_b",    bus.rf_we,         0);
        check("r0_stall_b", bus.core_stall[1], 0);
        bus.core_we = '0;
        tick();
        check("r0_we_c",    bus.rf_we,         1);
        check("r0_addr",    bus.rf_waddr,      5);
        check("r0_data",    bus.rf_wdata,      7);
        check("r0_core",    bus.rf_wcore,      1);
        check("r0_stall_c", bus.core_stall[1], 0);
        tick();
        check("r0_off",     bus.rf_we,         0);
        check("r0_idle",    bus.idle,          1);

        // Back-pressure on core 2 while the other cores keep their queues busy.
        do_reset();
        idx2 = 0;
        cnt2 = 0;
        acc2 = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (bus.rf_we && (bus.rf_wcore == 2'd2)) begin
                if (cnt2 < 4) begin
                    ga[cnt2] = bus.rf_waddr;
                    gd[cnt2] = bus.rf_wdata;
                end
                cnt2++;
            end
            if (acc2) idx2++;
            req(0, n < 12, 5'd20, 32'(n));
            req(1, n < 12, 5'd21, 32'(n));
            req(3, n < 12, 5'd23, 32'(n));
            if (idx2 < 4) req(2, 1'b1, 5'(idx2 + 1), 32'(32'hA + idx2));
            else          req(2, 1'b0, 5'd0, 32'd0);
            acc2 = bus.core_we[2] && !bus.core_stall[2];
            if (n == 1) check("bp_stall2_n1", bus.core_stall[2], 0);
            if (n == 2) check("bp_stall2_n2", bus.core_stall[2], 1);
            if (n == 3) check("bp_stall2_n3", bus.core_stall[2], 1);
            if (n == 4) check("bp_stall2_n4", bus.core_stall[2], 0);
            if (n == 5) check("bp_stall2_n5", bus.core_stall[2], 1);
            tick();
        end
        check("bp_count", 64'(cnt2), 4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("bp%0d_addr", k), ga[k], 64'(k + 1));
            check($sformatf("bp%0d_data", k), gd[k], 64'(32'hA + k));
        end
        check("bp_idle", bus.idle, 1);

        // Reset while three FIFOs hold data and a write is on the port.
        do_reset();
        req(0, 1'b1, 5'd7,  32'h70);
        req(1, 1'b1, 5'd8,  32'h80);
        req(2, 1'b1, 5'd13, 32'hD0);
        tick();
        tick();
        bus.core_we = '0;
        check("mr_busy_we",    bus.rf_we,      1);
        check("mr_busy_stall", bus.core_stall, 4'b0110);
        #3;
        reset_n = 1'b0;
        #1;
        check("mr_we_drop", bus.rf_we,      0);
        check("mr_idle",    bus.idle,       1);
        check("mr_stall",   bus.core_stall, 0);
        #4;
        reset_n = 1'b1;
        cnt_we  = 0;
        repeat (8) begin
            tick();
            if (bus.rf_we) cnt_we++;
        end
        check("mr_no_writes", 64'(cnt_we), 0);
        check("mr_idle_end",  bus.idle,    1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
